fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requester ports; legal range 2..16.
REQ-002 Parameter DATA_W, default 64: payload width per beat.
REQ-003 Parameter MAX_PKT, default 16: maximum beats per packet; legal range 2..65535.
REQ-004 Derived ID_W = $clog2(NUM_REQ); FIFO word width OUT_W = ID_W+1+DATA_W.
REQ-005 clk  in  1  single clock; all state is updated on posedge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 req_valid_i  in  NUM_REQ  per-port beat valid.
REQ-008 req_data_i  in  NUM_REQ*DATA_W  per-port payload; port p occupies bits [p*DATA_W +: DATA_W].
REQ-009 req_last_i  in  NUM_REQ  per-port end-of-packet marker.
REQ-010 req_ready_o  out  NUM_REQ  per-port accept; a beat transfers when valid and ready are both 1.
REQ-011 fifo_wr_req_o  out  1  write strobe to the shared sync FIFO.
REQ-012 fifo_wr_data_o  out  OUT_W  packed {port_id, last, data}.
REQ-013 fifo_full_i  in  1  FIFO full flag, registered in the FIFO.
REQ-014 lock_o  out  1  1 while the arbiter is locked on a packet.
REQ-015 grant_id_o  out  ID_W  currently selected port; valid only when any valid is asserted or lock_o=1.
REQ-016 pkt_err_o  out  1  sticky flag for an over-length packet.
REQ-017 beat_cnt_o  out  32  total beats written; wraps modulo 2^32.

Function
REQ-018 The FSM SHALL have two states: IDLE and LOCK.
REQ-019 In IDLE the block SHALL select a port combinationally in the same cycle.
- Candidate: the first port with valid=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
REQ-020 In LOCK the selected port SHALL be lock_id; all other ports SHALL see ready=0.
REQ-021 req_ready_o[sel] SHALL equal !fifo_full_i; the ready of every other port SHALL be 0.
- Ready does not depend on valid.
REQ-022 fifo_wr_req_o SHALL equal req_valid_i[sel] & !fifo_full_i & (IDLE ? any valid : 1).
- This is zero-latency, with no register between requester and FIFO.
REQ-023 fifo_wr_data_o SHALL equal {sel, req_last_i[sel], data of sel}.
- Don't-care when fifo_wr_req_o=0.
REQ-024 IDLE, accepted beat with last=0: next state LOCK, lock_id<=sel, pkt_cnt<=1.
REQ-025 IDLE, accepted beat with last=1: stay IDLE, rr_ptr<=sel+1 modulo NUM_REQ.
REQ-026 LOCK, accepted beat with last=1: next state IDLE, rr_ptr<=lock_id+1 modulo NUM_REQ.
REQ-027 LOCK, accepted beat with last=0 and pkt_cnt+1==MAX_PKT: set pkt_err_o=1, next state IDLE, rr_ptr<=lock_id+1.
- The packet is forcibly released.
REQ-028 LOCK, accepted beat otherwise: pkt_cnt increments.
REQ-029 LOCK with the locked port's valid=0 SHALL hold state, pkt_cnt and lock_id; no other port may be granted.
REQ-030 fifo_full_i=1 SHALL block all transfers; state, rr_ptr, pkt_cnt and beat_cnt_o SHALL hold.
REQ-031 beat_cnt_o SHALL increment by 1 on every cycle with fifo_wr_req_o=1.
REQ-032 pkt_err_o SHALL clear only on reset.
REQ-033 Input data SHALL never be stored; requesters hold data stable until the transfer.

Reset
REQ-034 While rst=1 the block SHALL hold: state IDLE, rr_ptr=0, lock_id=0, pkt_cnt=0, pkt_err_o=0, beat_cnt_o=0.
REQ-035 lock_o SHALL read 0 during and after reset.
REQ-036 req_ready_o and fifo_wr_req_o SHALL follow REQ-021/022 from these reset values.
REQ-037 Reset asserted mid-packet SHALL abandon the lock immediately, with no further FIFO write for that packet.
REQ-038 After reset release, port 0 SHALL have highest priority.

Verification
REQ-039 Ports 0..3 each valid with one single-beat packet (last=1), FIFO never full.
- FIFO receives ids 0,1,2,3 on consecutive cycles; beat_cnt_o=4.
REQ-040 Port 2 sends a 3-beat packet while port 1 stays valid.
- Writes have ids 2,2,2 with last=0,0,1; lock_o=1 for 2 cycles; the next write is id 1.
REQ-041 Mid-packet, drop port 0 valid for 2 cycles while port 3 is valid.
- No writes during those cycles; port 3 ready=0; the packet resumes on port 0.
REQ-042 fifo_full_i=1 for 5 cycles with all ports valid.
- fifo_wr_req_o=0 and every ready=0; grant order and beat_cnt_o unchanged after full drops.
REQ-043 MAX_PKT=4, port 1 streams last=0 continuously.
- After the 4th accepted beat: pkt_err_o=1, state IDLE, next grant goes to port 2 if it is valid.
REQ-044 Assert rst during the 2nd beat of a locked packet on port 3.
- Immediately: lock_o=0, beat_cnt_o=0, pkt_err_o=0.
- After release: port 0 wins over port 3.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Packet-aware round-robin arbiter feeding a shared synchronous FIFO write port.
// Zero-latency path: the selected requester drives the FIFO directly, nothing is buffered.
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int MAX_PKT = 16,
  localparam int ID_W   = $clog2(NUM_REQ),
  localparam int OUT_W  = ID_W + 1 + DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      fifo_wr_req_o,
  output logic [OUT_W-1:0]          fifo_wr_data_o,
  input  logic                      fifo_full_i,
  output logic                      lock_o,
  output logic [ID_W-1:0]           grant_id_o,
  output logic                      pkt_err_o,
  output logic [31:0]               beat_cnt_o
);

  localparam int CNT_W = $clog2(MAX_PKT + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]        r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_lock_id;
  logic [CNT_W-1:0]  r_pkt_cnt;
  logic              r_pkt_err;
  logic [31:0]       r_beat_cnt;

  logic [DATA_W-1:0] w_data_arr [NUM_REQ];
  logic [ID_W:0]     w_idx;
  logic [ID_W-1:0]   w_rr_sel;
  logic              w_rr_hit;
  logic [ID_W-1:0]   w_sel;
  logic [ID_W-1:0]   w_sel_next;
  logic              w_any_valid;
  logic              w_locked;
  logic              w_wr;
  logic              w_last;
  logic              w_max_hit;
  logic [NUM_REQ-1:0] w_ready;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
    assign w_data_arr[g] = req_data_i[g*DATA_W +: DATA_W];
  end

  // Search starts at rr_ptr and wraps; the extra index bit avoids overflow before the wrap.
  always_comb begin
    w_idx    = '0;
    w_rr_sel = r_rr_ptr;
    w_rr_hit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(i);
      if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
        w_idx = w_idx - (ID_W+1)'(NUM_REQ);
      end
      if (!w_rr_hit && req_valid_i[w_idx[ID_W-1:0]]) begin
        w_rr_sel = w_idx[ID_W-1:0];
        w_rr_hit = 1'b1;
      end
    end
  end

  assign w_any_valid = |req_valid_i;
  assign w_locked    = (r_state == S_LOCK);
  assign w_sel       = w_locked ? r_lock_id : w_rr_sel;
  assign w_sel_next  = (w_sel == ID_W'(NUM_REQ - 1)) ? '0 : w_sel + 1'b1;
  assign w_last      = req_last_i[w_sel];
  assign w_wr        = req_valid_i[w_sel] & ~fifo_full_i & (w_locked | w_any_valid);
  assign w_max_hit   = ((r_pkt_cnt + CNT_W'(1)) == CNT_W'(MAX_PKT));

  always_comb begin
    w_ready        = '0;
    w_ready[w_sel] = ~fifo_full_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_lock_id <= '0;
      r_pkt_cnt <= '0;
      r_pkt_err <= 1'b0;
    end else if (w_wr) begin
      if (!w_locked) begin
        if (w_last) begin
          r_rr_ptr <= w_sel_next;
        end else begin
          r_state   <= S_LOCK;
          r_lock_id <= w_sel;
          r_pkt_cnt <= CNT_W'(1);
        end
      end else if (w_last) begin
        r_state  <= S_IDLE;
        r_rr_ptr <= w_sel_next;
      end else if (w_max_hit) begin
        // Over-length packet: release the port so others are not starved.
        r_pkt_err <= 1'b1;
        r_state   <= S_IDLE;
        r_rr_ptr  <= w_sel_next;
      end else begin
        r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else if (w_wr) begin
      r_beat_cnt <= r_beat_cnt + 32'd1;
    end
  end

  assign req_ready_o    = w_ready;
  assign fifo_wr_req_o  = w_wr;
  assign fifo_wr_data_o = {w_sel, w_last, w_data_arr[w_sel]};
  assign lock_o         = w_locked;
  assign grant_id_o     = w_sel;
  assign pkt_err_o      = r_pkt_err;
  assign beat_cnt_o     = r_beat_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks of fifo_wr_arbiter against a packet-level reference model.
module tb_fifo_wr_arbiter;
  localparam int N   = 4;
  localparam int DW  = 16;
  localparam int MP  = 4;
  localparam int IDW = 2;
  localparam int OW  = IDW + 1 + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  valid;
  logic [N-1:0]  last;
  logic [N*DW-1:0] data;
  logic [N-1:0]  ready;
  logic          wr_req;
  logic [OW-1:0] wr_data;
  logic          full;
  logic          lock;
  logic [IDW-1:0] gid;
  logic          err;
  logic [31:0]   bcnt;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: owner of the current packet (-1 = none) and next priority port
  int          m_lock;
  int          m_ptr;
  int          m_cnt;
  bit          m_err;
  int unsigned m_beats;
  int          m_sel;
  bit          m_wr;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_PKT(MP)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(valid), .req_data_i(data), .req_last_i(last),
    .req_ready_o(ready),
    .fifo_wr_req_o(wr_req), .fifo_wr_data_o(wr_data), .fifo_full_i(full),
    .lock_o(lock), .grant_id_o(gid), .pkt_err_o(err), .beat_cnt_o(bcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lock  = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    m_err   = 1'b0;
    m_beats = 0;
  endtask

  task automatic model_check();
    int sel;
    bit found;
    bit exp_wr;
    logic [N-1:0] exp_rdy;
    logic [IDW-1:0] sel_id;
    found = 1'b0;
    sel   = m_ptr;
    if (m_lock >= 0) begin
      sel   = m_lock;
      found = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!found && valid[(m_ptr + k) % N]) begin
          sel   = (m_ptr + k) % N;
          found = 1'b1;
        end
      end
    end
    exp_wr = found && valid[sel] && !full;
    sel_id = sel[IDW-1:0];
    check("wr_req", wr_req, exp_wr);
    check("lock", lock, m_lock >= 0);
    check("pkt_err", err, m_err);
    check("beat_cnt", bcnt, m_beats);
    if (found) begin
      exp_rdy      = '0;
      exp_rdy[sel] = !full;
      check("ready", ready, exp_rdy);
      check("grant", gid, sel_id);
    end
    if (exp_wr) check("wr_data", wr_data, {sel_id, last[sel], data[sel*DW +: DW]});
    m_sel = sel;
    m_wr  = exp_wr;
  endtask

  task automatic model_update();
    if (!m_wr) return;
    m_beats++;
    if (m_lock < 0) begin
      if (last[m_sel]) m_ptr = (m_sel + 1) % N;
      else begin
        m_lock = m_sel;
        m_cnt  = 1;
      end
    end else if (last[m_sel]) begin
      m_lock = -1;
      m_ptr  = (m_sel + 1) % N;
    end else if (m_cnt + 1 == MP) begin
      m_err  = 1'b1;
      m_lock = -1;
      m_ptr  = (m_sel + 1) % N;
    end else begin
      m_cnt++;
    end
  endtask

  // Called at posedge+1 (or later in the low phase); returns at the next posedge+1.
  task automatic tick();
    #1;
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_lock", lock, 1'b0);
    check("rst_bcnt", bcnt, 32'd0);
    check("rst_err", err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_data();
    for (int p = 0; p < N; p++) data[p*DW +: DW] = DW'($urandom);
  endtask

  initial begin
    rst   = 1'b1;
    valid = '0;
    last  = '0;
    full  = 1'b0;
    data  = '0;
    model_reset();
    #2;
    check("init_lock", lock, 1'b0);
    check("init_bcnt", bcnt, 32'd0);
    check("init_err", err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single-beat packets from all ports: ids in order 0..3
    valid = 4'hF;
    last  = 4'hF;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      #1;
      check("t39_id", wr_data[OW-1 -: IDW], i);
      tick();
      valid[i] = 1'b0;
    end
    #1;
    check("t39_bcnt", bcnt, 32'd4);

    // 3-beat packet on port 2 while port 1 stays valid
    do_reset();
    valid = 4'b0010; last = 4'b0010; rand_data();
    tick();
    valid = 4'b0110; last = 4'b0000; rand_data();
    #1;
    check("t40_b1_id", wr_data[OW-1 -: IDW], 2);
    check("t40_b1_last", wr_data[DW], 1'b0);
    tick();
    #1;
    check("t40_b2_lock", lock, 1'b1);
    check("t40_b2_id", wr_data[OW-1 -: IDW], 2);
    tick();
    last = 4'b0100;
    #1;
    check("t40_b3_lock", lock, 1'b1);
    check("t40_b3_last", wr_data[DW], 1'b1);
    tick();
    valid = 4'b0010; last = 4'b0010;
    #1;
    check("t40_after_lock", lock, 1'b0);
    check("t40_next_id", wr_data[OW-1 -: IDW], 1);
    tick();

    // locked port 0 pauses while port 3 waits
    do_reset();
    valid = 4'b0001; last = 4'b0000; rand_data();
    tick();
    valid = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("t41_no_wr", wr_req, 1'b0);
      check("t41_rdy3", ready[3], 1'b0);
      tick();
    end
    valid = 4'b1001; last = 4'b0001;
    #1;
    check("t41_resume_id", wr_data[OW-1 -: IDW], 0);
    check("t41_resume_wr", wr_req, 1'b1);
    tick();
    valid = 4'b1000; last = 4'b1000;
    tick();

    // FIFO full blocks everything
    do_reset();
    valid = 4'hF; last = 4'hF; full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t42_wr", wr_req, 1'b0);
      check("t42_rdy", ready, 4'h0);
      tick();
    end
    full = 1'b0;
    #1;
    check("t42_bcnt", bcnt, 32'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t42_id", wr_data[OW-1 -: IDW], i);
      tick();
      valid[i] = 1'b0;
    end

    // over-length packet on port 1 with MAX_PKT=4
    do_reset();
    valid = 4'b0110; last = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      rand_data();
      #1;
      check("t43_id", wr_data[OW-1 -: IDW], 1);
      tick();
    end
    last = 4'b0100;
    #1;
    check("t43_err", err, 1'b1);
    check("t43_unlocked", lock, 1'b0);
    check("t43_next_id", wr_data[OW-1 -: IDW], 2);
    tick();

    // reset mid-packet on port 3 (pkt_err still set from the previous packet)
    valid = 4'b1000; last = 4'b0000; rand_data();
    tick();
    #1;
    check("t44_locked", lock, 1'b1);
    rst = 1'b1;
    model_reset();
    #1;
    check("t44_lock", lock, 1'b0);
    check("t44_bcnt", bcnt, 32'd0);
    check("t44_err", err, 1'b0);
    @(posedge clk);
    #1;
    check("t44_bcnt_hold", bcnt, 32'd0);
    rst = 1'b0;
    valid = 4'b1001; last = 4'b1001;
    #1;
    check("t44_prio0", wr_data[OW-1 -: IDW], 0);
    tick();

    // randomized traffic with occasional reset
    for (int c = 0; c < 3000; c++) begin
      valid = N'($urandom);
      last  = N'($urandom) & N'($urandom);
      full  = ($urandom_range(0, 4) == 0);
      rand_data();
      if ($urandom_range(0, 299) == 0) do_reset();
      else tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
